// File: rtl/prbs31_chk_pkg.sv
// Shared types and constants for the PRBS31 checker slice.
package prbs31_chk_pkg;

  // Checker state; the encodings double as the state code shown on uo_out[3:2].
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // x^31 + x^28 + 1: r(n) = r(n-28) ^ r(n-31)
  localparam int SH_W  = 31;
  localparam int TAP_A = 27;
  localparam int TAP_B = 30;

  localparam int FILL_W  = 5;   // counts the 31 fill bits in HUNT
  localparam int MATCH_W = 6;   // consecutive matches in VERIFY
  localparam int WIN_W   = 6;   // valid-bit position in the loss window
  localparam int WERR_W  = 4;   // errors within the current window
  localparam int ERR_W   = 16;  // total error counter
  localparam int BIT_W   = 24;  // total locked-bit counter

  // Next bit of the sequence as predicted from the register contents.
  function automatic logic prbs_predict(input logic [SH_W-1:0] sh);
    return sh[TAP_A] ^ sh[TAP_B];
  endfunction

endpackage

// File: rtl/prbs31_chk_if.sv
// Bundle between pin mapping and the checker core.
interface prbs31_chk_if;
  import prbs31_chk_pkg::*;

  logic             din;
  logic             valid;
  logic             clear;
  logic             lock;
  logic             err_pulse;
  logic [1:0]       state;
  logic [ERR_W-1:0] err_cnt;
  logic [BIT_W-1:0] bit_cnt;

  modport master (output din, valid, clear,
                  input  lock, err_pulse, state, err_cnt, bit_cnt);
  modport slave  (input  din, valid, clear,
                  output lock, err_pulse, state, err_cnt, bit_cnt);
endinterface

// File: rtl/prbs31_chk_core.sv
// PRBS31 checker core: shift register, acquisition FSM, error/bit counters.
module prbs31_chk_core
  import prbs31_chk_pkg::*;
#(
  parameter int LOCK_MATCHES = 32,
  parameter int LOSS_ERRORS  = 8,
  parameter int WINDOW_BITS  = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  prbs31_chk_if.slave   bus
);

  state_t              r_state, w_state_nxt;
  logic [SH_W-1:0]     r_sh, w_sh_nxt;
  logic [FILL_W-1:0]   r_fill, w_fill_nxt;
  logic [MATCH_W-1:0]  r_match, w_match_nxt;
  logic [WIN_W-1:0]    r_wbit, w_wbit_nxt;
  logic [WERR_W-1:0]   r_werr, w_werr_nxt;
  logic [ERR_W-1:0]    r_err, w_err_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic                r_pulse, w_pulse_nxt;
  logic                w_pred;
  logic                w_miss;
  logic                w_wrap;

  assign w_pred = prbs_predict(r_sh);
  assign w_miss = bus.din ^ w_pred;
  assign w_wrap = (r_wbit == WIN_W'(WINDOW_BITS - 1));

  // Register all checker state; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= ST_HUNT;
      r_sh    <= '0;
      r_fill  <= '0;
      r_match <= '0;
      r_wbit  <= '0;
      r_werr  <= '0;
      r_err   <= '0;
      r_bit   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_fill  <= w_fill_nxt;
      r_match <= w_match_nxt;
      r_wbit  <= w_wbit_nxt;
      r_werr  <= w_werr_nxt;
      r_err   <= w_err_nxt;
      r_bit   <= w_bit_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Next-state and counter update; only valid bits advance anything, clear overrides counting.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_wbit_nxt  = r_wbit;
    w_werr_nxt  = r_werr;
    w_err_nxt   = r_err;
    w_bit_nxt   = r_bit;
    w_pulse_nxt = 1'b0;

    if (bus.valid) begin
      case (r_state)
        ST_HUNT: begin
          w_sh_nxt = {r_sh[SH_W-2:0], bus.din};
          if (r_fill == FILL_W'(SH_W - 1)) begin
            w_state_nxt = ST_VERIFY;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
          end else begin
            w_fill_nxt = r_fill + FILL_W'(1);
          end
        end

        ST_VERIFY: begin
          w_sh_nxt = {r_sh[SH_W-2:0], bus.din};
          // An all-zero register predicts zeros forever, so it is never trusted.
          if ((r_sh == '0) || w_miss) begin
            w_state_nxt = ST_HUNT;
            w_fill_nxt  = '0;
            w_match_nxt = '0;
          end else if (r_match == MATCH_W'(LOCK_MATCHES - 1)) begin
            w_state_nxt = ST_LOCKED;
            w_match_nxt = '0;
            w_wbit_nxt  = '0;
            w_werr_nxt  = '0;
          end else begin
            w_match_nxt = r_match + MATCH_W'(1);
          end
        end

        ST_LOCKED: begin
          // Free-running: line errors never enter the register once locked.
          w_sh_nxt   = {r_sh[SH_W-2:0], w_pred};
          w_bit_nxt  = (r_bit == '1) ? r_bit : r_bit + BIT_W'(1);
          w_wbit_nxt = w_wrap ? '0 : r_wbit + WIN_W'(1);
          w_werr_nxt = w_wrap ? '0 : r_werr;
          if (w_miss) begin
            w_err_nxt   = (r_err == '1) ? r_err : r_err + ERR_W'(1);
            w_pulse_nxt = 1'b1;
            if (r_werr + WERR_W'(1) == WERR_W'(LOSS_ERRORS)) begin
              w_state_nxt = ST_HUNT;
              w_fill_nxt  = '0;
              w_wbit_nxt  = '0;
              w_werr_nxt  = '0;
            end else if (!w_wrap) begin
              w_werr_nxt = r_werr + WERR_W'(1);
            end
          end
        end

        default: begin
          w_state_nxt = ST_HUNT;
          w_fill_nxt  = '0;
        end
      endcase
    end

    if (bus.clear) begin
      w_err_nxt = '0;
      w_bit_nxt = '0;
    end
  end

  assign bus.lock      = (r_state == ST_LOCKED);
  assign bus.err_pulse = r_pulse;
  assign bus.state     = r_state;
  assign bus.err_cnt   = r_err;
  assign bus.bit_cnt   = r_bit;

endmodule

// File: rtl/tt_um_davidparent_prbs31_chk.sv
// Tiny Tapeout wrapper: pin mapping and counter display mux around the checker core.
module tt_um_davidparent_prbs31_chk
  import prbs31_chk_pkg::*;
#(
  parameter int LOCK_MATCHES = 32,
  parameter int LOSS_ERRORS  = 8,
  parameter int WINDOW_BITS  = 64
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  prbs31_chk_if w_bus ();
  logic w_unused;

  assign w_bus.din   = ui_in[0];
  assign w_bus.valid = ui_in[1];
  assign w_bus.clear = ui_in[2];

  prbs31_chk_core #(
    .LOCK_MATCHES (LOCK_MATCHES),
    .LOSS_ERRORS  (LOSS_ERRORS),
    .WINDOW_BITS  (WINDOW_BITS)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_bus.slave)
  );

  assign uo_out = {w_bus.err_cnt[3:0], w_bus.state, w_bus.err_pulse, w_bus.lock};
  assign uio_oe = 8'hFF;

  // Select which counter byte is shown on the bidirectional pins.
  always_comb begin
    uio_out = '0;
    case (ui_in[4:3])
      2'b00:   uio_out = w_bus.err_cnt[7:0];
      2'b01:   uio_out = w_bus.err_cnt[15:8];
      2'b10:   uio_out = w_bus.bit_cnt[15:8];
      default: uio_out = w_bus.bit_cnt[23:16];
    endcase
  end

  assign w_unused = ^{ena, uio_in, ui_in[7:5], w_bus.bit_cnt[7:0]};

endmodule

// File: doc/tt_um_davidparent_prbs31_chk.md
TT_UM_DAVIDPARENT_PRBS31_CHK -- requirements
Module: tt_um_davidparent_prbs31_chk

Interface
REQ-001 SHALL have parameter LOCK_MATCHES, default 32, consecutive correct predictions required to declare lock.
REQ-002 SHALL have parameter LOSS_ERRORS, default 8, errors within one window that force loss of lock.
REQ-003 SHALL have parameter WINDOW_BITS, default 64, valid bits per loss-detection window.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high (despite the name).
REQ-006 ena  input  1  always 1 when powered; ignored.
REQ-007 ui_in  input  8  [0] serial PRBS31 data in, [1] data valid, [2] synchronous counter clear, [4:3] display select, [7:5] unused.
REQ-008 uo_out  output  8  [0] lock, [1] error pulse, [3:2] state code, [7:4] err_cnt[3:0].
REQ-009 uio_in  input  8  unused.
REQ-010 uio_out  output  8  display byte selected by ui_in[4:3].
REQ-011 uio_oe  output  8  constant 8'hFF.

Function
REQ-012 Data in SHALL be sampled only on edges with valid=1; valid=0 edges SHALL leave shift register, state and all counters unchanged.
REQ-013 Checker SHALL hold 31-bit shift register sh; predicted bit = sh[27] XOR sh[30] (polynomial x^31+x^28+1, received r(n)=r(n-28)^r(n-31)).
REQ-014 State machine SHALL have states HUNT(code 0), VERIFY(1), LOCKED(2); code 3 unused.
REQ-015 HUNT: each valid bit shifts in as sh <= {sh[29:0], din}; after 31 valid bits SHALL enter VERIFY with match count 0.
REQ-016 VERIFY: shift in received bit; prediction match increments match count; mismatch SHALL return to HUNT with fill count 0.
REQ-017 VERIFY with sh == 0 SHALL return to HUNT; all-zero register SHALL never reach LOCKED.
REQ-018 VERIFY: the valid bit producing the LOCK_MATCHES-th consecutive match SHALL enter LOCKED; lock asserted the following cycle (63 valid bits total from reset at defaults).
REQ-019 LOCKED: sh SHALL shift in the predicted bit, not din (free-running local LFSR, immune to line errors).
REQ-020 LOCKED: din != prediction SHALL increment err_cnt (16-bit, saturating at 16'hFFFF) and assert error pulse for exactly one cycle after that edge.
REQ-021 LOCKED: every valid bit SHALL increment bit_cnt (24-bit, saturating at 24'hFFFFFF); no counting outside LOCKED.
REQ-022 Window: 6-bit valid-bit counter and 4-bit window-error counter in LOCKED; both SHALL clear on wrap after WINDOW_BITS valid bits.
REQ-023 Window-error count reaching LOSS_ERRORS SHALL enter HUNT on that edge; err_cnt and bit_cnt SHALL retain values.
REQ-024 Clear=1 SHALL zero err_cnt and bit_cnt at that edge; clear wins over a simultaneous increment; state and sh unaffected.
REQ-025 Display select: 00 err_cnt[7:0], 01 err_cnt[15:8], 10 bit_cnt[15:8], 11 bit_cnt[23:16]; combinational from registered counters.
REQ-026 All uo_out bits SHALL be registered or direct decodes of registered state; no combinational path from ui_in to uo_out.

Reset
REQ-027 rst_n=1 SHALL asynchronously force state HUNT, sh=0, fill/match/window counters 0, err_cnt=0, bit_cnt=0, error pulse 0.
REQ-028 Reset outputs: uo_out=8'h00, uio_out=8'h00, uio_oe=8'hFF.
REQ-029 Reset asserted mid-lock SHALL discard lock; reacquisition restarts from HUNT after release.

Structure
REQ-030 Package prbs31_chk_pkg SHALL hold state enum, state codes, tap positions (27, 30), register width 31 and counter widths.
REQ-031 One sub-module prbs31_chk_core SHALL contain sh, FSM and counters; top SHALL only map pins and the display mux.

Verification
REQ-032 Reset, feed generator stream (seed 31'd1, tx bit = lfsr[30]) with valid=1 -> lock=1 after 63 valid bits, err_cnt=0, state code 2.
REQ-033 After lock, invert one bit -> err_cnt=1, error pulse high exactly one cycle, lock stays 1, subsequent bits error-free.
REQ-034 Feed 500 zeros -> lock never asserts, err_cnt=0, state cycles HUNT/VERIFY only.
REQ-035 After lock, invert 8 bits within one 64-bit window -> lock drops on 8th error, err_cnt=8; clean stream relocks after 63 further valid bits.
REQ-036 Valid toggled every other cycle with same stream -> lock after 63 valid bits (~126 clocks), counters identical to REQ-032.
REQ-037 Assert clear on the same edge as an injected error -> err_cnt=0 next cycle, error pulse still 1.
